// File: rtl/apb_pkg.sv
// Shared definitions for the APB master slice.
//   apb_state_e : bus-phase state of the master (idle, setup, access, decode error)
//   Apb*        : default width/count parameters
//   sel_width() : slave-index width for a given slave count (at least 1 bit)
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDerr
  } apb_state_e;

  localparam int unsigned ApbAddrW          = 9;
  localparam int unsigned ApbDataW          = 8;
  localparam int unsigned ApbNumSlv         = 2;
  localparam int unsigned ApbTimeoutCycles  = 16;

  function automatic int unsigned sel_width(input int unsigned num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

// File: rtl/apb_master_n_if.sv
// Request/response and APB bus bundle for apb_master_n.
//   Host side : REQ_VALID/READY/WRITE/ADDR/WDATA, RSP_VALID/RDATA/ERR
//   APB side  : PSEL (one-hot), PENABLE, PWRITE, PADDR, PWDATA,
//               PRDATA (packed per slave), PREADY, PSLVERR (per slave)
// Modports: master (the bridge), slave (host and peripherals facing the bridge).
interface apb_master_n_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ApbAddrW,
  parameter int unsigned DATA_W  = ApbDataW,
  parameter int unsigned NUM_SLV = ApbNumSlv
) ();

  logic                        REQ_VALID;
  logic                        REQ_READY;
  logic                        REQ_WRITE;
  logic [ADDR_W-1:0]           REQ_ADDR;
  logic [DATA_W-1:0]           REQ_WDATA;
  logic                        RSP_VALID;
  logic [DATA_W-1:0]           RSP_RDATA;
  logic                        RSP_ERR;
  logic [NUM_SLV-1:0]          PSEL;
  logic                        PENABLE;
  logic                        PWRITE;
  logic [ADDR_W-1:0]           PADDR;
  logic [DATA_W-1:0]           PWDATA;
  logic [NUM_SLV*DATA_W-1:0]   PRDATA;
  logic [NUM_SLV-1:0]          PREADY;
  logic [NUM_SLV-1:0]          PSLVERR;

  modport master (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, PRDATA, PREADY, PSLVERR,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder: the top SEL_W address bits pick the slave.
//   addr_i    : address to decode
//   sel_o     : one-hot slave select (all zero on decode error)
//   dec_err_o : index does not name an existing slave
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ApbAddrW,
  parameter int unsigned NUM_SLV = ApbNumSlv
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] sel_o,
  output logic               dec_err_o
);

  localparam int unsigned SEL_W = sel_width(NUM_SLV);

  logic [SEL_W-1:0] idx;
  logic [31:0]      idx_ext;

  assign idx       = addr_i[ADDR_W-1 -: SEL_W];
  assign idx_ext   = 32'(idx);
  assign dec_err_o = (idx_ext >= NUM_SLV);

  always_comb begin
    sel_o = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel_o[i] = !dec_err_o && (idx_ext == i);
    end
  end

  // Offset bits below the slave index are not part of the decode.
  if (ADDR_W > SEL_W) begin : g_unused_lo
    logic unused_addr_lo;
    assign unused_addr_lo = ^addr_i[ADDR_W-SEL_W-1:0];
  end

endmodule

// File: rtl/apb_master_n.sv
// APB master bridging a valid/ready request port to NUM_SLV APB slaves.
//   CLK, RST : rising-edge clock, synchronous active-high reset
//   bus      : apb_master_n_if.master (host request/response + APB bus)
// Requests are accepted in IDLE or in the completing ACCESS cycle, so
// back-to-back transfers run at one per two cycles. Responses are a
// single-cycle RSP_VALID pulse; RSP_RDATA holds until the next response.
// Optional feature macro APB_MASTER_TIMEOUT_EN: abort an ACCESS phase after
// TIMEOUT_CYCLES wait cycles with an error response.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ApbAddrW,
  parameter int unsigned DATA_W         = ApbDataW,
  parameter int unsigned NUM_SLV        = ApbNumSlv,
  parameter int unsigned TIMEOUT_CYCLES = ApbTimeoutCycles
) (
  input logic            CLK,
  input logic            RST,
  apb_master_n_if.master bus
);

  apb_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [NUM_SLV-1:0] sel_q, sel_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_SLV-1:0] req_sel;
  logic               req_dec_err;
  logic               req_ready;
  logic               accept;
  logic               timeout;
  logic               pready_sel;
  logic               pslverr_sel;
  logic [DATA_W-1:0]  prdata_sel;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV)
  ) u_req_dec (
    .addr_i    (bus.REQ_ADDR),
    .sel_o     (req_sel),
    .dec_err_o (req_dec_err)
  );

  // AND-OR mux over the registered one-hot select; other slaves are ignored.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      if (sel_q[i]) begin
        pready_sel  = pready_sel  | bus.PREADY[i];
        pslverr_sel = pslverr_sel | bus.PSLVERR[i];
        prdata_sel  = prdata_sel  | bus.PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StSetup) begin
      wait_cnt_d = '0;
    end else if ((state_q == StAccess) && !pready_sel) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  assign timeout = (state_q == StAccess) && !pready_sel &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;

  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (pready_sel) begin
          req_ready   = 1'b1;
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata_sel;
          rsp_err_d   = pslverr_sel;
        end else if (timeout) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end
      end
      StDerr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new request overrides the IDLE return of a completing transfer.
    accept = bus.REQ_VALID && req_ready && !RST;
    if (accept) begin
      paddr_d  = bus.REQ_ADDR;
      pwdata_d = bus.REQ_WDATA;
      pwrite_d = bus.REQ_WRITE;
      sel_d    = req_sel;
      state_d  = req_dec_err ? StDerr : StSetup;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // REQ_READY is masked while RST is held so every output reads 0 in reset.
  assign bus.REQ_READY = req_ready && !RST;
  assign bus.RSP_VALID = rsp_valid_q;
  assign bus.RSP_RDATA = rsp_rdata_q;
  assign bus.RSP_ERR   = rsp_err_q;
  assign bus.PSEL      = ((state_q == StSetup) || (state_q == StAccess)) ? sel_q : '0;
  assign bus.PENABLE   = (state_q == StAccess);
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_n.sv
module tb_apb_master_n;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  apb_master_n_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2)) bus2 ();
  apb_master_n_if #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(3)) bus3 ();

  apb_master_n #(
    .ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT_CYCLES(4)
  ) dut2 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus2)
  );

  apb_master_n #(
    .ADDR_W(9), .DATA_W(8), .NUM_SLV(3), .TIMEOUT_CYCLES(4)
  ) dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus3)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (bus2.REQ_READY !== 1'b0) begin errors++;
      $display("FAIL rst_req_ready: got %b want 0", bus2.REQ_READY); end
    checks++; if (bus2.PSEL !== 2'b00 || bus2.PENABLE !== 1'b0) begin errors++;
      $display("FAIL rst_psel_pen: got %b/%b want 00/0", bus2.PSEL, bus2.PENABLE); end
    checks++; if (bus2.RSP_VALID !== 1'b0 || bus2.RSP_ERR !== 1'b0 || bus2.RSP_RDATA !== 8'h00)
      begin errors++; $display("FAIL rst_rsp: got %b/%b/%h want 0/0/00",
      bus2.RSP_VALID, bus2.RSP_ERR, bus2.RSP_RDATA); end
    checks++; if (bus2.PADDR !== 9'h000 || bus2.PWDATA !== 8'h00 || bus2.PWRITE !== 1'b0)
      begin errors++; $display("FAIL rst_bus: got %h/%h/%b want 000/00/0",
      bus2.PADDR, bus2.PWDATA, bus2.PWRITE); end
    RST = 1'b0;
    #1;
    checks++; if (bus2.REQ_READY !== 1'b1) begin errors++;
      $display("FAIL post_rst_ready: got %b want 1", bus2.REQ_READY); end
  endtask

  task automatic test_zero_wait_write();
    bus2.PREADY    = 2'b10;
    bus2.PSLVERR   = 2'b01;  // slave 0 error must be ignored
    bus2.REQ_WRITE = 1'b1;
    bus2.REQ_ADDR  = 9'h105;
    bus2.REQ_WDATA = 8'h5A;
    bus2.REQ_VALID = 1'b1;
    tick();
    bus2.REQ_VALID = 1'b0;
    checks++; if (bus2.PSEL !== 2'b10 || bus2.PENABLE !== 1'b0) begin errors++;
      $display("FAIL wr_c1_setup: got %b/%b want 10/0", bus2.PSEL, bus2.PENABLE); end
    checks++; if (bus2.PADDR !== 9'h105 || bus2.PWDATA !== 8'h5A || bus2.PWRITE !== 1'b1)
      begin errors++; $display("FAIL wr_c1_bus: got %h/%h/%b want 105/5a/1",
      bus2.PADDR, bus2.PWDATA, bus2.PWRITE); end
    tick();
    checks++; if (bus2.PSEL !== 2'b10 || bus2.PENABLE !== 1'b1 || bus2.RSP_VALID !== 1'b0)
      begin errors++; $display("FAIL wr_c2_access: got %b/%b/%b want 10/1/0",
      bus2.PSEL, bus2.PENABLE, bus2.RSP_VALID); end
    tick();
    checks++; if (bus2.RSP_VALID !== 1'b1 || bus2.RSP_ERR !== 1'b0 || bus2.RSP_RDATA !== 8'h00)
      begin errors++; $display("FAIL wr_c3_rsp: got %b/%b/%h want 1/0/00",
      bus2.RSP_VALID, bus2.RSP_ERR, bus2.RSP_RDATA); end
    checks++; if (bus2.PSEL !== 2'b00 || bus2.PENABLE !== 1'b0 || bus2.PADDR !== 9'h105)
      begin errors++; $display("FAIL wr_c3_idle: got %b/%b/%h want 00/0/105",
      bus2.PSEL, bus2.PENABLE, bus2.PADDR); end
    tick();
    checks++; if (bus2.RSP_VALID !== 1'b0) begin errors++;
      $display("FAIL wr_c4_pulse: got %b want 0", bus2.RSP_VALID); end
    bus2.PSLVERR = 2'b00;
  endtask

  task automatic test_read_wait();
    int pen_cnt = 0;
    int rsp_at  = 0;
    logic [7:0] rdata = 8'h00;
    bus2.PRDATA    = {8'hEE, 8'h3C};
    bus2.PREADY    = 2'b10;  // only the unselected slave is ready
    bus2.REQ_WRITE = 1'b0;
    bus2.REQ_ADDR  = 9'h023;
    bus2.REQ_VALID = 1'b1;
    tick();
    bus2.REQ_VALID = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (bus2.PENABLE === 1'b1) pen_cnt++;
      if (bus2.RSP_VALID === 1'b1 && rsp_at == 0) begin
        rsp_at = c;
        rdata  = bus2.RSP_RDATA;
      end
      if (c == 5) bus2.PREADY = 2'b11;
      tick();
    end
    checks++; if (pen_cnt != 4) begin errors++;
      $display("FAIL rd_penable_cycles: got %0d want 4", pen_cnt); end
    checks++; if (rsp_at != 6) begin errors++;
      $display("FAIL rd_latency: got %0d want 6", rsp_at); end
    checks++; if (rdata !== 8'h3C) begin errors++;
      $display("FAIL rd_data: got %h want 3c", rdata); end
    checks++; if (bus2.RSP_VALID !== 1'b0 || bus2.RSP_RDATA !== 8'h3C) begin errors++;
      $display("FAIL rd_hold: got %b/%h want 0/3c", bus2.RSP_VALID, bus2.RSP_RDATA); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] addr[4]  = '{9'h010, 9'h110, 9'h020, 9'h120};
    logic       wr[4]    = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] exp_d[4] = '{8'hA0, 8'hB1, 8'h00, 8'hB1};
    int k = 0;
    int nrsp = 0;
    int first_rsp = 0;
    int last_rsp = 0;
    logic acc;
    bus2.PRDATA    = {8'hB1, 8'hA0};
    bus2.PREADY    = 2'b11;
    bus2.REQ_ADDR  = addr[0];
    bus2.REQ_WRITE = wr[0];
    bus2.REQ_WDATA = 8'h11;
    bus2.REQ_VALID = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      acc = bus2.REQ_VALID && bus2.REQ_READY;
      tick();
      if (acc) begin
        k++;
        if (k < 4) begin
          bus2.REQ_ADDR  = addr[k];
          bus2.REQ_WRITE = wr[k];
        end else begin
          bus2.REQ_VALID = 1'b0;
        end
      end
      if (bus2.RSP_VALID === 1'b1) begin
        if (nrsp == 0) first_rsp = c;
        last_rsp = c;
        checks++; if (nrsp > 3 || bus2.RSP_RDATA !== exp_d[nrsp & 3] || bus2.RSP_ERR !== 1'b0)
          begin errors++; $display("FAIL b2b_rsp%0d: got %h/%b want %h/0",
          nrsp, bus2.RSP_RDATA, bus2.RSP_ERR, exp_d[nrsp & 3]); end
        nrsp++;
      end
      if (c <= 8) begin
        checks++; if (bus2.PSEL === 2'b00 || bus2.PENABLE !== ((c % 2) == 0)) begin errors++;
          $display("FAIL b2b_phase_c%0d: got psel %b pen %b want nonzero/%b",
          c, bus2.PSEL, bus2.PENABLE, ((c % 2) == 0)); end
      end
    end
    checks++; if (k != 4 || nrsp != 4) begin errors++;
      $display("FAIL b2b_counts: got acc %0d rsp %0d want 4/4", k, nrsp); end
    checks++; if (first_rsp != 3 || last_rsp != 9) begin errors++;
      $display("FAIL b2b_rsp_window: got %0d..%0d want 3..9", first_rsp, last_rsp); end
  endtask

  task automatic test_pslverr();
    bus2.PREADY    = 2'b01;
    bus2.PSLVERR   = 2'b01;
    bus2.REQ_WRITE = 1'b1;
    bus2.REQ_ADDR  = 9'h0AA;
    bus2.REQ_WDATA = 8'hC3;
    bus2.REQ_VALID = 1'b1;
    tick();
    bus2.REQ_VALID = 1'b0;
    tick();
    tick();
    checks++; if (bus2.RSP_VALID !== 1'b1 || bus2.RSP_ERR !== 1'b1) begin errors++;
      $display("FAIL slverr_rsp: got %b/%b want 1/1", bus2.RSP_VALID, bus2.RSP_ERR); end
    bus2.PSLVERR = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    bus2.PREADY    = 2'b00;
    bus2.REQ_WRITE = 1'b0;
    bus2.REQ_ADDR  = 9'h1F0;
    bus2.REQ_VALID = 1'b1;
    tick();
    bus2.REQ_VALID = 1'b0;
    tick();
    checks++; if (bus2.PSEL !== 2'b10 || bus2.PENABLE !== 1'b1) begin errors++;
      $display("FAIL rstmid_access: got %b/%b want 10/1", bus2.PSEL, bus2.PENABLE); end
    RST = 1'b1;
    tick();
    checks++; if (bus2.PSEL !== 2'b00 || bus2.PENABLE !== 1'b0 || bus2.RSP_VALID !== 1'b0)
      begin errors++; $display("FAIL rstmid_drop: got %b/%b/%b want 00/0/0",
      bus2.PSEL, bus2.PENABLE, bus2.RSP_VALID); end
    RST = 1'b0;
    bus2.PREADY = 2'b11;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (bus2.RSP_VALID !== 1'b0 || bus2.PSEL !== 2'b00) begin errors++;
        $display("FAIL rstmid_quiet_%0d: got %b/%b want 0/00", c, bus2.RSP_VALID, bus2.PSEL); end
    end
  endtask

  task automatic test_decode_err();
    bus3.PRDATA    = {8'h77, 8'h55, 8'h33};
    bus3.PREADY    = 3'b100;
    bus3.PSLVERR   = 3'b000;
    bus3.REQ_WRITE = 1'b0;
    bus3.REQ_ADDR  = 9'h100;  // index 2
    bus3.REQ_VALID = 1'b1;
    tick();
    bus3.REQ_VALID = 1'b0;
    checks++; if (bus3.PSEL !== 3'b100) begin errors++;
      $display("FAIL s3_psel: got %b want 100", bus3.PSEL); end
    tick();
    tick();
    checks++; if (bus3.RSP_VALID !== 1'b1 || bus3.RSP_RDATA !== 8'h77) begin errors++;
      $display("FAIL s3_rd: got %b/%h want 1/77", bus3.RSP_VALID, bus3.RSP_RDATA); end
    tick();
    bus3.REQ_ADDR  = 9'h180;  // index 3: no such slave
    bus3.REQ_VALID = 1'b1;
    tick();
    bus3.REQ_VALID = 1'b0;
    checks++; if (bus3.PSEL !== 3'b000 || bus3.PENABLE !== 1'b0 || bus3.RSP_VALID !== 1'b0 ||
                  bus3.REQ_READY !== 1'b0) begin errors++;
      $display("FAIL derr_c1: got %b/%b/%b/%b want 000/0/0/0",
      bus3.PSEL, bus3.PENABLE, bus3.RSP_VALID, bus3.REQ_READY); end
    tick();
    checks++; if (bus3.RSP_VALID !== 1'b1 || bus3.RSP_ERR !== 1'b1 || bus3.RSP_RDATA !== 8'h00 ||
                  bus3.PSEL !== 3'b000) begin errors++;
      $display("FAIL derr_c2: got %b/%b/%h/%b want 1/1/00/000",
      bus3.RSP_VALID, bus3.RSP_ERR, bus3.RSP_RDATA, bus3.PSEL); end
    tick();
    checks++; if (bus3.RSP_VALID !== 1'b0 || bus3.REQ_READY !== 1'b1) begin errors++;
      $display("FAIL derr_c3: got %b/%b want 0/1", bus3.RSP_VALID, bus3.REQ_READY); end
  endtask

  task automatic test_timeout();
    int pen_cnt = 0;
    int rsp_at  = 0;
    int bad     = 0;
    bus2.PRDATA    = {8'h99, 8'h42};
    bus2.PREADY    = 2'b00;
    bus2.REQ_WRITE = 1'b0;
    bus2.REQ_ADDR  = 9'h044;
    bus2.REQ_VALID = 1'b1;
    tick();
    bus2.REQ_VALID = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int c = 1; c <= 40 && rsp_at == 0; c++) begin
      if (bus2.PENABLE === 1'b1) begin
        pen_cnt++;
        if (pen_cnt == 4 && bus2.REQ_READY !== 1'b0) bad++;
      end
      if (bus2.RSP_VALID === 1'b1) begin
        rsp_at = c;
        if (bus2.RSP_ERR !== 1'b1 || bus2.RSP_RDATA !== 8'h00 || bus2.PSEL !== 2'b00 ||
            bus2.PENABLE !== 1'b0) bad++;
      end
      if (rsp_at == 0) tick();
    end
    checks++; if (rsp_at != 6 || pen_cnt != 4) begin errors++;
      $display("FAIL tmo_timing: got rsp %0d pen %0d want 6/4", rsp_at, pen_cnt); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL tmo_abort_values: got %0d bad cycles want 0", bad); end
`else
    for (int c = 1; c <= 120; c++) begin
      if (c >= 2 && (bus2.PENABLE !== 1'b1 || bus2.PSEL !== 2'b01)) bad++;
      if (bus2.RSP_VALID !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL notmo_stuck: got %0d bad cycles want 0", bad); end
    bus2.PREADY = 2'b01;
    tick();
    checks++; if (bus2.RSP_VALID !== 1'b1 || bus2.RSP_RDATA !== 8'h42 || bus2.RSP_ERR !== 1'b0)
      begin errors++; $display("FAIL notmo_finish: got %b/%h/%b want 1/42/0",
      bus2.RSP_VALID, bus2.RSP_RDATA, bus2.RSP_ERR); end
    rsp_at = 1;
    pen_cnt = 0;
`endif
    bus2.PREADY = 2'b00;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    bus2.REQ_VALID = 1'b0; bus2.REQ_WRITE = 1'b0; bus2.REQ_ADDR = '0; bus2.REQ_WDATA = '0;
    bus2.PRDATA = '0; bus2.PREADY = '0; bus2.PSLVERR = '0;
    bus3.REQ_VALID = 1'b0; bus3.REQ_WRITE = 1'b0; bus3.REQ_ADDR = '0; bus3.REQ_WDATA = '0;
    bus3.PRDATA = '0; bus3.PREADY = '0; bus3.PSLVERR = '0;
    test_reset();
    test_zero_wait_write();
    test_read_wait();
    test_back_to_back();
    test_pslverr();
    test_reset_mid();
    test_decode_err();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_n.md
# apb_master_n

Parametrised APB master bridging a simple valid/ready request port to an APB bus with `NUM_SLV` selectable slaves. It generalises the single-channel two-slave master to configurable address/data widths and slave count. It adds back-to-back transfers, per-slave response muxing, decode-error reporting and an optional access timeout. It sits between a host-side controller (e.g. the UART/TX front end) and the APB peripheral slaves.

## Interface
Parameters:
- `ADDR_W`, 9: APB address width.
- `DATA_W`, 8: APB data width.
- `NUM_SLV`, 2: number of slaves, from 1 to 16. `SEL_W = max(1, $clog2(NUM_SLV))`.
- `TIMEOUT_CYCLES`, 16: ACCESS-wait limit. Used only with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `CLK` in 1: the single clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `REQ_VALID` in 1: host request valid.
- `REQ_READY` out 1: master can accept a request.
- `REQ_WRITE` in 1: 1 = write, 0 = read.
- `REQ_ADDR` in `ADDR_W`: request address.
- `REQ_WDATA` in `DATA_W`: write data.
- `RSP_VALID` out 1: one-cycle response pulse.
- `RSP_RDATA` out `DATA_W`: read data. Held until the next response.
- `RSP_ERR` out 1: PSLVERR, decode error or timeout.
- `PSEL` out `NUM_SLV`: one-hot slave select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PADDR` out `ADDR_W`: APB address.
- `PWDATA` out `DATA_W`: APB write data.
- `PRDATA` in `NUM_SLV*DATA_W`: per-slave read data. Slave i is at bits `[i*DATA_W +: DATA_W]`.
- `PREADY` in `NUM_SLV`: per-slave ready.
- `PSLVERR` in `NUM_SLV`: per-slave error.

## Operation
- **States:** IDLE, SETUP, ACCESS, DERR (decode error).
- **Decode:** slave index = `REQ_ADDR[ADDR_W-1 -: SEL_W]`. An index ≥ `NUM_SLV` is a decode error.
- **Request handshake:** `REQ_READY` = (state==IDLE) or (state==ACCESS and selected `PREADY`=1, without a timeout abort).
  - A transfer is accepted when `REQ_VALID` and `REQ_READY` are both 1.
  - On accept, address, data, direction and index are registered into `PADDR`, `PWDATA`, `PWRITE` and an internal index.
- **IDLE:**
  - Accept with a valid index → SETUP.
  - Accept with a decode error → DERR.
  - No accept → stay in IDLE.
- **SETUP:** `PSEL[idx]`=1, `PENABLE`=0. Always → ACCESS.
- **ACCESS:** `PSEL[idx]`=1, `PENABLE`=1.
  - Selected `PREADY`=0 → stay in ACCESS.
  - Selected `PREADY`=1 → the transfer completes:
    - `RSP_RDATA` loads the selected `PRDATA` on reads, or 0 on writes.
    - `RSP_ERR` loads the selected `PSLVERR`.
    - Next state is SETUP if a new request is accepted in the same cycle, otherwise IDLE.
- **DERR:** no `PSEL`. Produces `RSP_ERR`=1 with `RSP_RDATA`=0. → IDLE.
- **Idle bus values:** `PADDR`, `PWDATA` and `PWRITE` hold their last values in IDLE. `PSEL` = 0 and `PENABLE` = 0 outside SETUP/ACCESS.
- **Unselected slaves:** `PREADY`, `PSLVERR` and `PRDATA` of unselected slaves are ignored.
- **Reset values:** all outputs are 0, state is IDLE. `REQ_READY` becomes 1 in the first cycle after reset.
- **Reset mid-transfer:** the transfer is dropped with no response. `PSEL` and `PENABLE` are 0 in the cycle after the reset edge.

## Timing
- Accept at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2. With a zero-wait slave, `RSP_VALID`=1 in cycle 3.
- Accept → response latency is `3 + wait_states` cycles. A decode-error response arrives 2 cycles after accept.
- **Back-to-back:** accepting in the completing ACCESS cycle makes the next cycle SETUP, with no IDLE gap. Sustained rate is one transfer per 2 cycles.
- **Response pulse:** `RSP_VALID` is a single-cycle pulse with no backpressure. The host must sample it.

## Configuration
- **`APB_MASTER_TIMEOUT_EN` defined:**
  - A wait counter clears on SETUP and increments each ACCESS cycle in which `PREADY`=0.
  - On the cycle where the counter equals `TIMEOUT_CYCLES-1` and `PREADY` is still 0, the transfer aborts. The next cycle has `PSEL`=0 and `PENABLE`=0, `RSP_VALID`=1, `RSP_ERR`=1 and `RSP_RDATA`=0, and the state is IDLE.
  - `REQ_READY` is 0 in the abort cycle.
  - `PREADY`=1 in the limit cycle is a normal completion.
- **Not defined:** there is no counter, and ACCESS waits indefinitely.

## Structure
- **Shared package `apb_pkg`:** holds the `apb_state_e` enum (IDLE, SETUP, ACCESS, DERR) and the default width localparams.
- **Sub-module `apb_addr_decode`:** combinational. Maps the address to a one-hot select and the `dec_err` flag, and is reused by the interconnect.

## Test plan
- Zero-wait write: `NUM_SLV`=2, write 0x5A to addr 0x105 → `PSEL`=2'b10 in cycles 1–2, `PENABLE` in cycle 2, `RSP_VALID`=1 in cycle 3 with `RSP_ERR`=0.
- Read with 3 wait states from slave 0: `PRDATA` = 0x3C → `RSP_RDATA`=0x3C at accept+6, `PENABLE` high for 4 cycles.
- Back-to-back: `REQ_VALID` held high for 4 requests → exactly one SETUP between ACCESS phases, 4 responses in 8 cycles.
- Decode error: `NUM_SLV`=3, `SEL_W`=2, addr index 3 → no `PSEL`, `RSP_ERR`=1 two cycles after accept.
- `PSLVERR`=1 on completion → `RSP_ERR`=1. Separately, `RST` asserted during ACCESS → `PSEL`=0, no `RSP_VALID`.
- With `APB_MASTER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, `PREADY` held 0 → abort after 4 ACCESS cycles with `RSP_ERR`=1. Without the macro → the master stays in ACCESS for 100+ cycles.
